// File: rtl/window_spill_fill_pkg.sv
// Shared window-control types: FSM states and register-file window commands.
// Also used by the register file's user to decode win_add_sub.
package window_spill_fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPILL_RD,
        SPILL_WR,
        FILL_RD,
        FILL_WR,
        ADVANCE,
        RETREAT
    } state_t;

    localparam logic [1:0]  WIN_ADD       = 2'b10;
    localparam logic [1:0]  WIN_SUB       = 2'b01;
    localparam logic [1:0]  WIN_HOLD      = 2'b00;

    localparam logic [11:0] SPILL_CNT_MAX = 12'hFFF;
    localparam logic [15:0] WIN_WORDS     = 16'd4;

endpackage

// File: rtl/window_spill_fill_reg.sv
// Generic enabled register with asynchronous active-low reset to RESET_VAL.
// Latency: q updates one cycle after en. Backpressure: none (plain storage).
// Backpressure: not applicable.
module window_spill_fill_reg #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/window_spill_fill.sv
// Register-window controller: advances/retreats windows, spilling/filling 4 words to memory.
// Latency: 1 cycle plain, 4*(2+W)+1 cycles with spill/fill (W = mem_ack wait per word).
// Backpressure: requests are sampled only in IDLE and dropped while busy; memory stalls on mem_ack.
module window_spill_fill
    import window_spill_fill_pkg::*;
#(
    parameter logic [15:0] SPILL_BASE = 16'hF000,
    parameter int unsigned MAX_RES    = 7
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        save_req,
    input  logic        restore_req,
    output logic        busy,
    output logic        ack,
    output logic        underflow,
    output logic [1:0]  win_add_sub,
    output logic [4:0]  rf_sel,
    input  logic [15:0] rf_rdata,
    output logic [15:0] rf_wdata,
    output logic        rf_we_L,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [2:0] RES_MAX = 3'(MAX_RES);

    state_t      state, nxt_state;
    logic [4:0]  cur_idx, old_idx;
    logic [2:0]  res_cnt;
    logic [11:0] spill_cnt;
    logic [1:0]  k;
    logic        xfer;
    logic [15:0] spill_ptr, ptr_d;
    logic        ptr_en;
    logic        underflow_set;
    logic [15:0] k_ext, k_dn_ext;

    assign k_ext    = {14'd0, k};
    assign k_dn_ext = {14'd0, k - 2'd1};

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state   = state;
        busy        = 1'b1;
        ack         = 1'b0;
        win_add_sub = WIN_HOLD;
        mem_req     = 1'b0;
        rf_sel      = 5'd0;
        rf_we_L     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // Saturated spill area: the save still completes, nothing is written out.
                if (save_req) begin
                    if (res_cnt < RES_MAX || spill_cnt == SPILL_CNT_MAX) begin
                        nxt_state = ADVANCE;
                    end else begin
                        nxt_state = SPILL_RD;
                    end
                end else if (restore_req) begin
                    if (res_cnt > 3'd1) begin
                        nxt_state = RETREAT;
                    end else if (spill_cnt != 12'd0) begin
                        nxt_state = FILL_RD;
                    end
                end
            end
            SPILL_RD: begin
                rf_sel    = old_idx + {3'd0, k};
                nxt_state = SPILL_WR;
            end
            SPILL_WR: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    nxt_state = (k == 2'd3) ? ADVANCE : SPILL_RD;
                end
            end
            FILL_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    nxt_state = FILL_WR;
                end
            end
            FILL_WR: begin
                rf_sel    = cur_idx - 5'd4 + {3'd0, k};
                rf_we_L   = 1'b0;
                nxt_state = (k == 2'd0) ? RETREAT : FILL_RD;
            end
            ADVANCE: begin
                win_add_sub = WIN_ADD;
                ack         = 1'b1;
                nxt_state   = IDLE;
            end
            RETREAT: begin
                win_add_sub = WIN_SUB;
                ack         = 1'b1;
                nxt_state   = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign underflow_set = (state == IDLE) && !save_req && restore_req &&
                           (res_cnt == 3'd1) && (spill_cnt == 12'd0);

    assign ptr_en = xfer && (state == ADVANCE || state == RETREAT);
    assign ptr_d  = (state == ADVANCE) ? spill_ptr + WIN_WORDS : spill_ptr - WIN_WORDS;

    window_spill_fill_reg #(
        .WIDTH     (16),
        .RESET_VAL (SPILL_BASE)
    ) u_spill_ptr (
        .clock   (clock),
        .reset_L (reset_L),
        .en      (ptr_en),
        .d       (ptr_d),
        .q       (spill_ptr)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cur_idx   <= 5'd0;
            old_idx   <= 5'd0;
            res_cnt   <= 3'd1;
            spill_cnt <= 12'd0;
            k         <= 2'd0;
            xfer      <= 1'b0;
            underflow <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            rf_wdata  <= 16'd0;
        end else begin
            underflow <= underflow_set;
            case (state)
                IDLE: begin
                    if (nxt_state == SPILL_RD) begin
                        k    <= 2'd0;
                        xfer <= 1'b1;
                    end
                    // Fill walks the top window downward, starting at its last word.
                    if (nxt_state == FILL_RD) begin
                        k        <= 2'd3;
                        xfer     <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= spill_ptr - WIN_WORDS + 16'd3;
                    end
                end
                SPILL_RD: begin
                    mem_wdata <= rf_rdata;
                    mem_addr  <= spill_ptr + k_ext;
                    mem_we    <= 1'b1;
                end
                SPILL_WR: begin
                    if (nxt_state == SPILL_RD) begin
                        k <= k + 2'd1;
                    end
                end
                FILL_RD: begin
                    if (mem_ack) begin
                        rf_wdata <= mem_rdata;
                    end
                end
                FILL_WR: begin
                    if (nxt_state == FILL_RD) begin
                        k        <= k - 2'd1;
                        mem_addr <= spill_ptr - WIN_WORDS + k_dn_ext;
                    end
                end
                ADVANCE: begin
                    cur_idx <= cur_idx + 5'd4;
                    xfer    <= 1'b0;
                    if (xfer) begin
                        old_idx   <= old_idx + 5'd4;
                        spill_cnt <= spill_cnt + 12'd1;
                    end else if (res_cnt < RES_MAX) begin
                        res_cnt <= res_cnt + 3'd1;
                    end
                end
                RETREAT: begin
                    cur_idx <= cur_idx - 5'd4;
                    xfer    <= 1'b0;
                    if (xfer) begin
                        old_idx   <= cur_idx - 5'd4;
                        spill_cnt <= spill_cnt - 12'd1;
                    end else begin
                        res_cnt <= res_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_window_spill_fill.sv
// Scoreboard bench for window_spill_fill: a window-stack reference model predicts memory,
// register-file and ack/underflow events; a negedge monitor pops and compares them.
module tb_window_spill_fill;

    localparam int K_MEMW = 1;
    localparam int K_MEMR = 2;
    localparam int K_RFW  = 3;
    localparam int K_ACK  = 4;
    localparam int K_UND  = 5;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] d;
        int          t;
    } ev_t;

    logic        clock;
    logic        reset_L;
    logic        save_req, restore_req;
    logic        busy, ack, underflow;
    logic [1:0]  win_add_sub;
    logic [4:0]  rf_sel;
    logic [15:0] rf_rdata, rf_wdata;
    logic        rf_we_L;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int w_cfg = 1;
    bit ack_en = 0;
    int req_cnt = 0;

    logic [15:0] env_mem   [0:65535];
    logic [15:0] model_mem [0:65535];
    logic [15:0] env_rf    [0:31];
    logic [15:0] model_rf  [0:31];

    logic [4:0]  m_cur, m_old;
    int          m_res, m_cnt;
    logic [15:0] m_ptr;

    ev_t q[$];

    window_spill_fill dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .save_req    (save_req),
        .restore_req (restore_req),
        .busy        (busy),
        .ack         (ack),
        .underflow   (underflow),
        .win_add_sub (win_add_sub),
        .rf_sel      (rf_sel),
        .rf_rdata    (rf_rdata),
        .rf_wdata    (rf_wdata),
        .rf_we_L     (rf_we_L),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    assign rf_rdata = env_rf[rf_sel];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push(int kind, logic [15:0] a, logic [15:0] d, int t);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        e.t    = t;
        q.push_back(e);
    endfunction

    task automatic expect_ev(input string nm, input int kind, input logic [15:0] a,
                             input logic [15:0] d, input int now);
        ev_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected kind=%0d a=%h d=%h at cyc %0d, expected no event",
                     nm, kind, a, d, now);
            return;
        end
        e = q.pop_front();
        if (e.kind != kind || e.a !== a || e.d !== d || (e.t >= 0 && e.t != now)) begin
            bad++;
            $display("FAIL %s: got kind=%0d a=%h d=%h cyc=%0d expected kind=%0d a=%h d=%h cyc=%0d",
                     nm, kind, a, d, now, e.kind, e.a, e.d, e.t);
        end
    endtask

    // Memory responder and output monitor share one negedge process to keep ordering fixed.
    always @(negedge clock) begin
        if (!reset_L) begin
            mem_ack = 1'b0;
            req_cnt = 0;
        end else begin
            if (mem_req) begin
                if (!ack_en) chk("mem_req_unexpected", 64'd1, 64'd0);
                req_cnt++;
                if (ack_en && req_cnt == w_cfg + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = env_mem[mem_addr];
                    if (mem_we) env_mem[mem_addr] = mem_wdata;
                    expect_ev("mem_access", mem_we ? K_MEMW : K_MEMR, mem_addr,
                              mem_we ? mem_wdata : 16'h0, cyc);
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                req_cnt = 0;
                mem_ack = 1'b0;
            end
            if (!rf_we_L) begin
                env_rf[rf_sel] = rf_wdata;
                expect_ev("rf_write", K_RFW, {11'd0, rf_sel}, rf_wdata, cyc);
            end
            if (ack) expect_ev("ack", K_ACK, {14'd0, win_add_sub}, 16'h0, cyc);
            else     chk("win_hold", {62'd0, win_add_sub}, 64'd0);
            if (underflow) expect_ev("underflow", K_UND, {14'd0, win_add_sub}, 16'h0, cyc);
        end
    end

    function automatic void model_reset();
        m_cur = 5'd0;
        m_old = 5'd0;
        m_res = 1;
        m_cnt = 0;
        m_ptr = 16'hF000;
    endfunction

    function automatic void model_save(int c);
        if (m_res < 7) begin
            push(K_ACK, 16'h2, 16'h0, c + 1);
            m_res++;
        end else if (m_cnt < 4095) begin
            for (int kk = 0; kk < 4; kk++) begin
                logic [15:0] a;
                logic [4:0]  r;
                a = m_ptr + 16'(kk);
                r = m_old + 5'(kk);
                model_mem[a] = model_rf[r];
                push(K_MEMW, a, model_rf[r], -1);
            end
            push(K_ACK, 16'h2, 16'h0, c + 4 * (2 + w_cfg) + 1);
            m_old = m_old + 5'd4;
            m_ptr = m_ptr + 16'd4;
            m_cnt++;
        end else begin
            push(K_ACK, 16'h2, 16'h0, c + 1);
        end
        m_cur = m_cur + 5'd4;
    endfunction

    function automatic void model_restore(int c);
        if (m_res > 1) begin
            push(K_ACK, 16'h1, 16'h0, c + 1);
            m_res--;
            m_cur = m_cur - 5'd4;
        end else if (m_cnt > 0) begin
            for (int kk = 3; kk >= 0; kk--) begin
                logic [15:0] a;
                logic [4:0]  r;
                a = m_ptr - 16'd4 + 16'(kk);
                r = m_cur - 5'd4 + 5'(kk);
                push(K_MEMR, a, 16'h0, -1);
                push(K_RFW, {11'd0, r}, model_mem[a], -1);
                model_rf[r] = model_mem[a];
            end
            push(K_ACK, 16'h1, 16'h0, c + 4 * (2 + w_cfg) + 1);
            m_old = m_cur - 5'd4;
            m_ptr = m_ptr - 16'd4;
            m_cnt--;
            m_cur = m_cur - 5'd4;
        end else begin
            push(K_UND, 16'h0, 16'h0, c + 1);
        end
    endfunction

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0) break;
            @(negedge clock);
            #1;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d events outstanding, expected 0", q.size());
            q.delete();
        end
        @(negedge clock);
    endtask

    // Called at a negedge with the DUT idle; extra re-pulses save while the DUT is busy.
    task automatic issue(input bit s, input bit r, input bit extra);
        int c;
        c = cyc;
        if (s)      model_save(c);
        else if (r) model_restore(c);
        save_req    = s;
        restore_req = r;
        @(negedge clock);
        save_req    = 1'b0;
        restore_req = 1'b0;
        if (extra && s) begin
            save_req = 1'b1;
            @(negedge clock);
            save_req = 1'b0;
        end
        drain();
    endtask

    initial begin
        int  op;
        int  c;
        bit  found;
        save_req    = 1'b0;
        restore_req = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0;
        reset_L     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            env_rf[i]   = 16'($urandom);
            model_rf[i] = env_rf[i];
        end
        model_reset();
        repeat (3) @(negedge clock);

        chk("rst_busy",      {63'd0, busy}, 64'd0);
        chk("rst_ack",       {63'd0, ack}, 64'd0);
        chk("rst_underflow", {63'd0, underflow}, 64'd0);
        chk("rst_mem_req",   {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we",    {63'd0, mem_we}, 64'd0);
        chk("rst_win",       {62'd0, win_add_sub}, 64'd0);
        chk("rst_rf_we_L",   {63'd0, rf_we_L}, 64'd1);
        chk("rst_rf_sel",    {59'd0, rf_sel}, 64'd0);
        chk("rst_mem_addr",  {48'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {48'd0, mem_wdata}, 64'd0);
        chk("rst_rf_wdata",  {48'd0, rf_wdata}, 64'd0);
        chk("rst_spill_ptr", {48'd0, dut.spill_ptr}, 64'hF000);
        reset_L = 1'b1;
        @(negedge clock);

        issue(1'b0, 1'b1, 1'b0);
        chk("underflow_cur_idx", {59'd0, dut.cur_idx}, 64'd0);
        chk("underflow_res_cnt", {61'd0, dut.res_cnt}, 64'd1);

        ack_en = 1'b0;
        repeat (6) issue(1'b1, 1'b0, 1'b0);
        chk("six_saves_cur_idx", {59'd0, dut.cur_idx}, 64'd24);
        chk("six_saves_res_cnt", {61'd0, dut.res_cnt}, 64'd7);

        ack_en = 1'b1;
        w_cfg  = 1;
        issue(1'b1, 1'b0, 1'b0);
        chk("spill_ptr_after_spill", {48'd0, dut.spill_ptr}, 64'hF004);
        chk("old_idx_after_spill",   {59'd0, dut.old_idx}, 64'd4);
        chk("cur_idx_after_spill",   {59'd0, dut.cur_idx}, 64'd28);

        repeat (7) issue(1'b0, 1'b1, 1'b0);
        chk("spill_cnt_after_fill", {52'd0, dut.spill_cnt}, 64'd0);
        chk("spill_ptr_after_fill", {48'd0, dut.spill_ptr}, 64'hF000);
        chk("cur_idx_after_fill",   {59'd0, dut.cur_idx}, 64'd0);

        issue(1'b1, 1'b1, 1'b0);
        chk("both_req_res_cnt", {61'd0, dut.res_cnt}, 64'd2);

        while (m_res < 7) issue(1'b1, 1'b0, 1'b0);
        w_cfg = 2;
        issue(1'b1, 1'b0, 1'b1);
        chk("dropped_save_spill_cnt", {52'd0, dut.spill_cnt}, 64'd1);

        for (int n = 0; n < 120; n++) begin
            w_cfg = $urandom_range(1, 3);
            op    = $urandom_range(0, 5);
            case (op)
                0, 1:    issue(1'b1, 1'b0, 1'b0);
                2, 3:    issue(1'b0, 1'b1, 1'b0);
                4:       issue(1'b1, 1'b1, 1'b0);
                default: issue(1'b1, 1'b0, 1'b1);
            endcase
        end
        chk("random_cur_idx",   {59'd0, dut.cur_idx}, {59'd0, m_cur});
        chk("random_spill_ptr", {48'd0, dut.spill_ptr}, {48'd0, m_ptr});

        while (m_res < 7) issue(1'b1, 1'b0, 1'b0);
        w_cfg = 3;
        c = cyc;
        model_save(c);
        save_req = 1'b1;
        @(negedge clock);
        save_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("spill_wr_reached", {63'd0, found}, 64'd1);
        reset_L = 1'b0;
        #1;
        chk("midreset_mem_req", {63'd0, mem_req}, 64'd0);
        chk("midreset_busy",    {63'd0, busy}, 64'd0);
        q.delete();
        repeat (3) begin
            @(negedge clock);
            chk("reset_hold_mem_req", {63'd0, mem_req}, 64'd0);
        end
        reset_L = 1'b1;
        model_reset();
        @(negedge clock);
        chk("post_reset_res_cnt",   {61'd0, dut.res_cnt}, 64'd1);
        chk("post_reset_spill_ptr", {48'd0, dut.spill_ptr}, 64'hF000);
        chk("post_reset_spill_cnt", {52'd0, dut.spill_cnt}, 64'd0);
        issue(1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
